// File: rtl/timer_irq_ctrl_if.sv
// CPU data-port bus as seen by the interval timer.
// The CPU drives the address and strobes; the timer returns combinational load data and hit.
interface timer_irq_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        rd;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, wdata, we, rd, input rdata, hit);
  modport slave  (input addr, wdata, we, rd, output rdata, hit);
endinterface

// File: rtl/timer_irq_ctrl.sv
// Memory-mapped interval timer (TH reload, TL counter, TCON control/status).
// It raises a registered interrupt when TL overflows and IE is set.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  timer_irq_ctrl_if.slave  bus,
  output logic             irqout
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [31:0] th, tl, th_nxt, tl_nxt;
  logic        en, ie, st, en_nxt, ie_nxt, st_nxt;
  logic [15:0] pre, pre_nxt;
  logic        aligned, sel_th, sel_tl, sel_tcon;
  logic        wr_th, wr_tl, wr_tcon;
  logic        tick, ovf;

  assign aligned  = (bus.addr[1:0] == 2'b00);
  assign sel_th   = aligned && (bus.addr == BASE_ADDR);
  assign sel_tl   = aligned && (bus.addr == BASE_ADDR + 32'd4);
  assign sel_tcon = aligned && (bus.addr == BASE_ADDR + 32'd8);
  assign bus.hit  = sel_th | sel_tl | sel_tcon;

  assign wr_th    = bus.we & sel_th;
  assign wr_tl    = bus.we & sel_tl;
  assign wr_tcon  = bus.we & sel_tcon;

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (sel_th)        bus.rdata = th;
      else if (sel_tl)   bus.rdata = tl;
      else if (sel_tcon) bus.rdata = {29'd0, st, ie, en};
    end
  end

  assign tick = en && (pre == PRE_LAST);
  assign ovf  = tick && (tl == 32'hFFFF_FFFF);

  // Software writes are applied last so they win over the same-cycle count/reload,
  // except that a TCON write still folds in an overflow seen with the old IE.
  always_comb begin
    th_nxt  = th;
    tl_nxt  = tl;
    pre_nxt = pre;
    en_nxt  = en;
    ie_nxt  = ie;
    st_nxt  = st;
    if (en)        pre_nxt = tick ? 16'd0 : pre + 16'd1;
    if (tick)      tl_nxt  = ovf ? th : tl + 32'd1;
    if (ovf && ie) st_nxt  = 1'b1;
    if (wr_th)     th_nxt  = bus.wdata;
    if (wr_tl) begin
      tl_nxt  = bus.wdata;
      pre_nxt = 16'd0;
      st_nxt  = st;
    end
    if (wr_tcon) begin
      en_nxt = bus.wdata[0];
      ie_nxt = bus.wdata[1];
      st_nxt = bus.wdata[2] | (ovf & ie);
      if (!bus.wdata[0]) pre_nxt = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th     <= '0;
      tl     <= '0;
      pre    <= '0;
      en     <= 1'b0;
      ie     <= 1'b0;
      st     <= 1'b0;
      irqout <= 1'b0;
    end else begin
      th     <= th_nxt;
      tl     <= tl_nxt;
      pre    <= pre_nxt;
      en     <= en_nxt;
      ie     <= ie_nxt;
      st     <= st_nxt;
      irqout <= ie & st;
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: vector table, hand-written corner sequences and a random run
// compared against a behavioural model, on a PRESCALE=1 and a PRESCALE=4 instance.
module tb_timer_irq_ctrl;

  localparam logic [31:0] TH_A = 32'h40000000;
  localparam logic [31:0] TL_A = 32'h40000004;
  localparam logic [31:0] TC_A = 32'h40000008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic        we, rd;
  logic        irq1, irq4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  timer_irq_ctrl_if b1 ();
  timer_irq_ctrl_if b4 ();
  assign b1.addr = addr;  assign b1.wdata = wdata;  assign b1.we = we;  assign b1.rd = rd;
  assign b4.addr = addr;  assign b4.wdata = wdata;  assign b4.we = we;  assign b4.rd = rd;

  timer_irq_ctrl #(.BASE_ADDR(TH_A), .PRESCALE(1)) dut  (.clk(clk), .reset(reset), .bus(b1), .irqout(irq1));
  timer_irq_ctrl #(.BASE_ADDR(TH_A), .PRESCALE(4)) dut4 (.clk(clk), .reset(reset), .bus(b4), .irqout(irq4));

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic        w;
    logic        r;
    logic        xhit;
    logic [31:0] xrd;
    logic        xirq;
  } vec_t;
  vec_t tbl[20];

  // Behavioural model, index 0 = PRESCALE 1, index 1 = PRESCALE 4.
  int          P[2] = '{1, 4};
  logic [31:0] m_th[2], m_tl[2];
  logic        m_en[2], m_ie[2], m_st[2], m_irq[2];
  int          m_ph[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic w, input logic r);
    @(negedge clk);
    addr = a; wdata = wd; we = w; rd = r;
    #1;
  endtask

  function automatic logic mhit(input logic [31:0] a);
    return (a == TH_A) || (a == TL_A) || (a == TC_A);
  endfunction

  function automatic logic [31:0] m_rdata(input int k);
    if (!rd)        return 32'd0;
    if (addr == TH_A) return m_th[k];
    if (addr == TL_A) return m_tl[k];
    if (addr == TC_A) return {29'd0, m_st[k], m_ie[k], m_en[k]};
    return 32'd0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_th[k] = '0; m_tl[k] = '0; m_en[k] = 0; m_ie[k] = 0; m_st[k] = 0; m_irq[k] = 0; m_ph[k] = 0;
    end
  endtask

  task automatic m_adv(input int k);
    logic        tick, ovf, wr, nen, nie, nst;
    logic [31:0] ntl, nth;
    int          nph;
    tick = m_en[k] && (((m_ph[k] + 1) % P[k]) == 0);
    ovf  = tick && (m_tl[k] == 32'hFFFFFFFF);
    nph  = m_en[k] ? (m_ph[k] + 1) % P[k] : 0;
    ntl  = tick ? (ovf ? m_th[k] : m_tl[k] + 32'd1) : m_tl[k];
    nst  = m_st[k] | (ovf & m_ie[k]);
    nth  = m_th[k]; nen = m_en[k]; nie = m_ie[k];
    wr   = we && mhit(addr);
    if (wr && addr == TH_A) nth = wdata;
    if (wr && addr == TL_A) begin ntl = wdata; nph = 0; nst = m_st[k]; end
    if (wr && addr == TC_A) begin
      nen = wdata[0]; nie = wdata[1]; nst = wdata[2] | (ovf & m_ie[k]);
      if (!wdata[0]) nph = 0;
    end
    m_irq[k] = m_ie[k] & m_st[k];
    m_th[k] = nth; m_tl[k] = ntl; m_en[k] = nen; m_ie[k] = nie; m_st[k] = nst; m_ph[k] = nph;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int j;
    logic [31:0] a, wd;
    logic w, r;

    tbl[0]  = '{TC_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'd0,         1'b0};
    tbl[1]  = '{TH_A + 32'hC,       32'd0,         1'b0, 1'b1, 1'b0, 32'd0,         1'b0};
    tbl[2]  = '{TH_A + 32'd2,       32'd0,         1'b0, 1'b1, 1'b0, 32'd0,         1'b0};
    tbl[3]  = '{TC_A,               32'hFFFFFFFF,  1'b1, 1'b0, 1'b1, 32'd0,         1'b0};
    tbl[4]  = '{TC_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'd7,         1'b0};
    tbl[5]  = '{TC_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'd7,         1'b1};
    tbl[6]  = '{TC_A,               32'd0,         1'b1, 1'b0, 1'b1, 32'd0,         1'b1};
    tbl[7]  = '{TL_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'd3,         1'b1};
    tbl[8]  = '{TC_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'd0,         1'b0};
    tbl[9]  = '{TH_A,               32'hFFFFFC18,  1'b1, 1'b0, 1'b1, 32'd0,         1'b0};
    tbl[10] = '{TL_A,               32'hFFFFFFFF,  1'b1, 1'b0, 1'b1, 32'd0,         1'b0};
    tbl[11] = '{TC_A,               32'd3,         1'b1, 1'b0, 1'b1, 32'd0,         1'b0};
    tbl[12] = '{TC_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'd3,         1'b0};
    tbl[13] = '{TL_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'hFFFFFC18,  1'b0};
    tbl[14] = '{TC_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'd7,         1'b1};
    tbl[15] = '{TC_A,               32'd1,         1'b1, 1'b0, 1'b1, 32'd0,         1'b1};
    tbl[16] = '{TC_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'd1,         1'b1};
    tbl[17] = '{TC_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'd1,         1'b0};
    tbl[18] = '{TC_A,               32'd3,         1'b1, 1'b0, 1'b1, 32'd0,         1'b0};
    tbl[19] = '{TC_A,               32'd0,         1'b0, 1'b1, 1'b1, 32'd3,         1'b0};

    reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; rd = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].a, tbl[i].wd, tbl[i].w, tbl[i].r);
      chk($sformatf("tbl%0d_hit", i), 32'(b1.hit), 32'(tbl[i].xhit));
      chk($sformatf("tbl%0d_rdata", i), b1.rdata, tbl[i].xrd);
      chk($sformatf("tbl%0d_irq", i), 32'(irq1), 32'(tbl[i].xirq));
    end

    // Second overflow must come 1000 ticks after the first one.
    j = 0;
    while (j < 1100) begin
      step(TC_A, 0, 1'b0, 1'b1);
      if (b1.rdata[2]) break;
      j++;
    end
    chk("ovf_period", 32'(j), 32'd993);
    chk("irq_before_rise", 32'(irq1), 32'd0);
    step(TC_A, 0, 1'b0, 1'b1);
    chk("irq_after_ovf", 32'(irq1), 32'd1);
    chk("tcon_after_ovf", b1.rdata, 32'd7);

    // TCON write colliding with an overflow keeps ST.
    step(TC_A, 32'd0, 1'b1, 1'b0);
    step(TH_A, 32'd0, 1'b1, 1'b0);
    step(TL_A, 32'hFFFFFFFF, 1'b1, 1'b0);
    step(TC_A, 32'd3, 1'b1, 1'b0);
    step(TC_A, 32'd1, 1'b1, 1'b0);
    step(TC_A, 32'd0, 1'b0, 1'b1);
    chk("coll_tcon", b1.rdata, 32'd5);
    chk("coll_irq0", 32'(irq1), 32'd0);
    step(TC_A, 32'd0, 1'b0, 1'b0);
    chk("coll_irq1", 32'(irq1), 32'd0);

    // TL write colliding with an overflow discards it.
    step(TC_A, 32'd3, 1'b1, 1'b0);
    step(TL_A, 32'hFFFFFFFF, 1'b1, 1'b0);
    step(TL_A, 32'd5, 1'b1, 1'b0);
    step(TL_A, 32'd0, 1'b0, 1'b1);
    chk("tlcoll_tl", b1.rdata, 32'd5);
    step(TC_A, 32'd0, 1'b0, 1'b1);
    chk("tlcoll_tcon", b1.rdata, 32'd3);

    // Prescale by 4 on the second instance.
    step(TC_A, 32'd0, 1'b1, 1'b0);
    step(TL_A, 32'd0, 1'b1, 1'b0);
    step(TC_A, 32'd1, 1'b1, 1'b0);
    for (int s = 1; s <= 13; s++) begin
      step(TL_A, 32'd0, 1'b0, 1'b1);
      chk($sformatf("pre4_s%0d", s), b4.rdata, 32'((s - 1) / 4));
    end
    step(TC_A, 32'd0, 1'b1, 1'b0);
    for (int s = 1; s <= 3; s++) begin
      step(TL_A, 32'd0, 1'b0, 1'b1);
      chk($sformatf("pre4_hold%0d", s), b4.rdata, 32'd3);
    end
    step(TC_A, 32'd1, 1'b1, 1'b0);
    for (int s = 1; s <= 5; s++) begin
      step(TL_A, 32'd0, 1'b0, 1'b1);
      chk($sformatf("pre4_re%0d", s), b4.rdata, 32'(3 + (s - 1) / 4));
    end

    // Asynchronous reset in the middle of counting.
    step(TH_A, 32'h1234, 1'b1, 1'b0);
    step(TC_A, 32'd7, 1'b1, 1'b0);
    step(TC_A, 32'd0, 1'b0, 1'b0);
    step(TC_A, 32'd0, 1'b0, 1'b0);
    chk("pre_reset_irq", 32'(irq1), 32'd1);
    rd = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("rst_tcon", b1.rdata, 32'd0);
    chk("rst_irq", 32'(irq1), 32'd0);
    chk("rst_irq4", 32'(irq4), 32'd0);
    addr = TH_A;
    #1 chk("rst_th", b1.rdata, 32'd0);
    addr = TL_A;
    #1 chk("rst_tl", b1.rdata, 32'd0);
    rd = 1'b0;
    #0.5 chk("rst_rd0", b1.rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();

    // Random traffic against the behavioural model.
    for (int i = 0; i < 2000; i++) begin
      int op;
      op = $urandom_range(0, 11);
      w = 1'b0; r = 1'b0; wd = $urandom; a = TC_A;
      case (op)
        0, 1: begin a = TH_A; w = 1'b1; wd = 32'hFFFFFFFF - $urandom_range(0, 30); end
        2, 3: begin a = TL_A; w = 1'b1; wd = 32'hFFFFFFFF - $urandom_range(0, 40); end
        4:    begin a = TC_A; w = 1'b1; wd = $urandom | 32'($urandom_range(0, 3) != 0); end
        5:    begin w = 1'b1; a = TH_A + 32'($urandom_range(1, 3)); end
        6:    begin w = 1'b1; a = TH_A + 32'hC; end
        7, 8, 9: begin
          r = 1'b1;
          case ($urandom_range(0, 5))
            0: a = TH_A;
            1: a = TL_A;
            2: a = TC_A;
            3: a = TH_A + 32'd2;
            4: a = TH_A + 32'hC;
            default: a = $urandom;
          endcase
        end
        default: begin a = $urandom; end
      endcase
      step(a, wd, w, r);
      chk($sformatf("rnd%0d_hit1", i), 32'(b1.hit), 32'(mhit(a)));
      chk($sformatf("rnd%0d_rd1", i), b1.rdata, m_rdata(0));
      chk($sformatf("rnd%0d_irq1", i), 32'(irq1), 32'(m_irq[0]));
      chk($sformatf("rnd%0d_rd4", i), b4.rdata, m_rdata(1));
      chk($sformatf("rnd%0d_irq4", i), 32'(irq4), 32'(m_irq[1]));
      m_adv(0);
      m_adv(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Memory-mapped interval timer and interrupt source on the CPU peripheral bus at base 0x40000000.
- Holds the reload register TH (offset 0x0), the counter TL (offset 0x4) and the control/status register TCON (offset 0x8).
- Raises the interrupt that vectors the CPU to 0x4. The 7-segment scan ISR is paced by it.
- The ISR clears and re-arms the interrupt through TCON.

Parameters:
- BASE_ADDR, 32'h40000000, byte address of TH; TL = BASE+4, TCON = BASE+8.
- PRESCALE, 1, clock cycles per counter tick (legal range 1..65535).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  bus byte address from the CPU data port.
- wdata  in  32  store data.
- we  in  1  store strobe; one write per clk cycle.
- rd  in  1  load strobe.
- rdata  out  32  load data, combinational.
- hit  out  1  addr selects one of the three registers; combinational.
- irqout  out  1  interrupt request to the CPU, registered.

Behaviour:
- Reset values, applied asynchronously: TH=0, TL=0, TCON=3'b000, prescaler=0, irqout=0.
- TCON bits:
  - bit0 EN: counter enable.
  - bit1 IE: interrupt enable.
  - bit2 ST: status, set by hardware.
  - Bits 31:3 read as 0 and ignore writes.
- Decode:
  - hit=1 only for addr == BASE, BASE+4 or BASE+8, full 32-bit compare.
  - addr[1:0] must be 0; misaligned addresses are not a hit.
- Read:
  - When rd & hit, rdata = the selected register (TCON zero-extended). Otherwise rdata=0.
  - There are no read side effects.
- Prescaler:
  - While EN=1, the prescaler counts 0..PRESCALE-1 and produces tick=1 in the cycle it equals PRESCALE-1, then wraps to 0.
  - While EN=0, the prescaler holds at 0.
  - With PRESCALE=1, tick=EN every cycle.
- Counter on tick:
  - If TL == 32'hFFFFFFFF: TL <= TH and ovf=1.
  - Otherwise TL <= TL+1, 32-bit modular.
- Status:
  - On ovf with IE=1, ST <= 1 at the same edge as the reload.
  - On ovf with IE=0, ST is unchanged.
- irqout is registered: irqout <= IE & ST. It therefore follows the register contents one cycle later.
- Period: with TL starting at TH, the reload/ovf ticks are (2^32 - TH) ticks apart. Example: TH=-1000 gives 1000 ticks.
- Writes (we & hit) take effect at the next edge:
  - TH write: the new TH is used by any later reload. If ovf occurs in the same cycle, the reload uses the old TH.
  - TL write: TL <= wdata and the prescaler clears to 0. It overrides a same-cycle increment or reload, and that cycle's ovf is discarded (ST is not set by it).
  - TCON write: EN <= wdata[0], IE <= wdata[1], ST <= wdata[2] | (ovf & old IE). A same-cycle overflow is never lost.
  - TCON write with EN going 1->0: the prescaler clears at the same edge.
- IE=0 with ST=1: irqout=0. When IE is set again, irqout rises one cycle later. This is the ISR exit path: write TCON with bit1 set.
- Reset asserted mid-count clears everything immediately. Counting resumes only after software sets EN.

Test Plan:
- Reset: assert reset mid-count with TCON=3 -> TH=TL=TCON=0 and irqout=0 immediately; rdata=0 with rd=0.
- Wrap: PRESCALE=1; write TH=32'hFFFFFC18, TL=32'hFFFFFFFF, TCON=3.
  - Next edge: TL=32'hFFFFFC18, ST=1, TCON reads 7; irqout=1 one cycle later.
  - Next ovf 1000 cycles after the first.
- ISR clear: with ST=1, write TCON = 7 & 32'hFFFFFFF9 -> TCON=1, irqout=0 next cycle.
  - Then write TCON=3 -> irqout stays 0 until the next ovf, then 1.
- Collision: with TL=32'hFFFFFFFF, EN=1, IE=1, write TCON=1 in the ovf cycle -> TCON reads 5 and irqout=0.
  - Separately, write TL=5 in an ovf cycle -> TL=5 and ST unchanged.
- Prescale: PRESCALE=4, TL=0, TCON=1 -> TL=1 after 4 cycles and TL=3 after 12.
  - Clearing EN holds TL; re-enabling restarts a full 4-cycle tick.
- Decode: read 0x4000000C -> hit=0, rdata=0; read 0x40000002 -> hit=0.
  - Write TCON=32'hFFFFFFFF -> reads 7.
